// File: rtl/spi_cmd_ctrl_if.sv
// spi_cmd_ctrl_if: single-beat memory bus between the SPI command sequencer
// and the cart-side memory.
//   mem_req   master->slave  request, held until mem_ack
//   mem_we    master->slave  1 = write, 0 = read; stable while mem_req
//   mem_addr  master->slave  ADDR_W-bit address; stable while mem_req
//   mem_wdata master->slave  write data; stable while mem_req
//   mem_ack   slave->master  one-cycle completion strobe
//   mem_rdata slave->master  read data, valid with mem_ack
interface spi_cmd_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ack;
    logic [7:0]        mem_rdata;

    modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                    input  mem_ack, mem_rdata);
    modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                    output mem_ack, mem_rdata);
endinterface

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: command sequencer on the byte interface of the SPI slave.
// Frames received bytes into command / address / data phases, issues
// single-beat memory requests and preloads the next byte to shift out.
// Transactions are framed by an idle timeout (there is no chip select).
// Commands: 01 write, 02 read, 9F ID/status, anything else is discarded.
// Optional feature: define SPI_CMD_AUTOINC_EN for burst address increment;
// without it the address is fixed for the whole transaction.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   spi_busy        SPI slave busy
//   spi_in_byte     received byte, valid on the busy falling edge
//   spi_out_byte    byte shifted out during the next SPI byte
//   mem             memory bus (spi_cmd_ctrl_if master)
//   err_ovr         sticky: write byte dropped or read data late
module spi_cmd_ctrl #(
    parameter int         ADDR_W  = 16,
    parameter int         TIMEOUT = 1024,
    parameter logic [7:0] ID_BYTE = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_busy,
    input  logic [7:0]            spi_in_byte,
    output logic [7:0]            spi_out_byte,
    spi_cmd_ctrl_if.master        mem,
    output logic                  err_ovr
);
    localparam int AB  = ADDR_W / 8;
    localparam int AIW = (AB > 1) ? $clog2(AB) : 1;
    localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {S_CMD, S_ADDR, S_WDATA, S_RDATA, S_ID, S_DISCARD} state_t;

    state_t            state_q, state_d;
    logic              busy_q;
    logic              is_rd_q, is_rd_d;
    logic [AIW-1:0]    aidx_q, aidx_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;      // working address pointer
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;  // address latched for the bus
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        out_q, out_d;
    logic              err_q, err_d;
    logic              snap_q, snap_d;    // err_ovr captured by the ID command
    logic              id_first_q, id_first_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;

    logic byte_done, ack, issue_rd;

    assign byte_done = busy_q & ~spi_busy;
    assign ack       = req_q & mem.mem_ack;

    always_comb begin
        state_d    = state_q;
        is_rd_d    = is_rd_q;
        aidx_d     = aidx_q;
        ptr_d      = ptr_q;
        req_d      = req_q;
        we_d       = we_q;
        maddr_d    = maddr_q;
        wdata_d    = wdata_q;
        out_d      = out_q;
        err_d      = err_q;
        snap_d     = snap_q;
        id_first_d = id_first_q;
        tcnt_d     = tcnt_q;
        issue_rd   = 1'b0;

        // Ack is handled before byte_done so a same-cycle ack frees the bus
        // for the next request without flagging an overrun.
        if (ack) begin
            req_d = 1'b0;
            if (we_q) begin
`ifdef SPI_CMD_AUTOINC_EN
                ptr_d = ptr_q + 1'b1;
`endif
            end else if (state_q == S_RDATA) begin
                if (spi_busy) err_d = 1'b1;   // byte already shifting: too late
                else          out_d = mem.mem_rdata;
            end
        end

        if (byte_done) begin
            case (state_q)
                S_CMD: begin
                    aidx_d = '0;
                    case (spi_in_byte)
                        8'h01: begin state_d = S_ADDR; is_rd_d = 1'b0; end
                        8'h02: begin state_d = S_ADDR; is_rd_d = 1'b1; end
                        8'h9F: begin
                            state_d    = S_ID;
                            out_d      = ID_BYTE;
                            snap_d     = err_q;
                            err_d      = 1'b0;
                            id_first_d = 1'b1;
                        end
                        default: state_d = S_DISCARD;
                    endcase
                end
                S_ADDR: begin
                    // MSB byte first: shift the new byte in at the bottom
                    ptr_d  = ADDR_W'({ptr_q, spi_in_byte});
                    aidx_d = aidx_q + 1'b1;
                    if (aidx_q == AIW'(AB - 1)) begin
                        if (is_rd_q) begin
                            issue_rd = 1'b1;
                            state_d  = S_RDATA;
                        end else begin
                            state_d  = S_WDATA;
                        end
                    end
                end
                S_WDATA: begin
                    if (req_d) begin
                        err_d = 1'b1;             // previous write still pending
                    end else begin
                        req_d   = 1'b1;
                        we_d    = 1'b1;
                        wdata_d = spi_in_byte;
                        maddr_d = ptr_d;
                    end
                end
                S_RDATA: begin
                    out_d = 8'hFF;
                    if (!req_d) issue_rd = 1'b1;
                end
                S_ID: begin
                    out_d      = id_first_q ? {7'b0, snap_q} : 8'hFF;
                    id_first_d = 1'b0;
                end
                default: ;
            endcase
        end

        if (issue_rd) begin
            req_d   = 1'b1;
            we_d    = 1'b0;
            maddr_d = ptr_d;
`ifdef SPI_CMD_AUTOINC_EN
            ptr_d   = ptr_d + 1'b1;
`endif
        end

        // Idle timeout; the return to S_CMD waits for any outstanding request.
        if (spi_busy || state_q == S_CMD) begin
            tcnt_d = '0;
        end else if (tcnt_q != TW'(TIMEOUT - 1)) begin
            tcnt_d = tcnt_q + 1'b1;
        end else if (!req_q) begin
            tcnt_d  = '0;
            state_d = S_CMD;
            out_d   = 8'hFF;
        end

        // The byte being shifted must not change under the shifter.
        if (spi_busy) out_d = out_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_CMD;
            busy_q     <= 1'b0;
            is_rd_q    <= 1'b0;
            aidx_q     <= '0;
            ptr_q      <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            maddr_q    <= '0;
            wdata_q    <= '0;
            out_q      <= 8'hFF;
            err_q      <= 1'b0;
            snap_q     <= 1'b0;
            id_first_q <= 1'b0;
            tcnt_q     <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= spi_busy;
            is_rd_q    <= is_rd_d;
            aidx_q     <= aidx_d;
            ptr_q      <= ptr_d;
            req_q      <= req_d;
            we_q       <= we_d;
            maddr_q    <= maddr_d;
            wdata_q    <= wdata_d;
            out_q      <= out_d;
            err_q      <= err_d;
            snap_q     <= snap_d;
            id_first_q <= id_first_d;
            tcnt_q     <= tcnt_d;
        end
    end

    assign spi_out_byte  = out_q;
    assign err_ovr       = err_q;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = maddr_q;
    assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Bench for spi_cmd_ctrl: directed frame table, hand sequences for
// overrun / ID status / timeout framing / reset, then random frames checked
// against a transaction-level model of the command protocol.
module tb_spi_cmd_ctrl;
    localparam int ADDR_W   = 16;
    localparam int TIMEOUT  = 64;
    localparam int BUSY_CYC = 8;
    localparam int GAP      = 5;
`ifdef SPI_CMD_AUTOINC_EN
    localparam logic [15:0] INC = 16'd1;
`else
    localparam logic [15:0] INC = 16'd0;
`endif
    localparam bit AUTO = (INC == 16'd1);

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_busy;
    logic [7:0] spi_in_byte;
    logic [7:0] spi_out_byte;
    logic       err_ovr;

    always #5 clk = ~clk;

    spi_cmd_ctrl_if #(.ADDR_W(ADDR_W)) mif ();

    spi_cmd_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .ID_BYTE(8'hA5)) dut (
        .clk          (clk),
        .rst          (rst),
        .spi_busy     (spi_busy),
        .spi_in_byte  (spi_in_byte),
        .spi_out_byte (spi_out_byte),
        .mem          (mif),
        .err_ovr      (err_ovr)
    );

    typedef struct packed { logic we; logic [15:0] addr; logic [7:0] data; } txn_t;
    typedef struct packed {
        logic [3:0]       nb;
        logic [5:0][7:0]  mosi;
        logic [5:0][7:0]  miso;
        logic [1:0]       nt;
        txn_t [2:0]       t;
    } vec_t;

    int checks = 0, errors = 0;
    txn_t       log_q[$], exp_log[$];
    logic [7:0] tx_q[$], rx_q[$], exp_rx[$];
    logic [7:0] ram       [logic [15:0]];
    logic [7:0] model_mem [logic [15:0]];
    int  ack_lat  = 2;
    int  cnt      = 0;
    bit  hold_ack = 0;

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h3C;
    endfunction
    function automatic logic [7:0] ram_rd(input logic [15:0] a);
        return ram.exists(a) ? ram[a] : init_val(a);
    endfunction
    function automatic logic [7:0] model_rd(input logic [15:0] a);
        return model_mem.exists(a) ? model_mem[a] : init_val(a);
    endfunction
    function automatic txn_t tx(input logic we, input logic [15:0] a, input logic [7:0] d);
        return txn_t'({we, a, d});
    endfunction
    function automatic logic [5:0][7:0] b6(input logic [7:0] a0, a1, a2, a3, a4, a5);
        logic [5:0][7:0] r;
        r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3; r[4] = a4; r[5] = a5;
        return r;
    endfunction
    function automatic txn_t [2:0] t3(input txn_t a, b, c);
        txn_t [2:0] r;
        r[0] = a; r[1] = b; r[2] = c;
        return r;
    endfunction

    // Memory responder: acks ack_lat cycles after the request is seen.
    always @(negedge clk) begin
        if (rst || mif.mem_ack) begin
            mif.mem_ack = 1'b0;
            cnt = 0;
        end else if (mif.mem_req && !hold_ack) begin
            cnt++;
            if (cnt >= ack_lat) begin
                if (mif.mem_we) ram[mif.mem_addr] = mif.mem_wdata;
                else            mif.mem_rdata = ram_rd(mif.mem_addr);
                log_q.push_back(tx(mif.mem_we, mif.mem_addr,
                                   mif.mem_we ? mif.mem_wdata : mif.mem_rdata));
                mif.mem_ack = 1'b1;
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One SPI byte: miso is what the slave holds when busy rises.
    task automatic spi_byte(input logic [7:0] b);
        @(negedge clk);
        rx_q.push_back(spi_out_byte);
        spi_busy = 1'b1;
        repeat (BUSY_CYC - 1) @(negedge clk);
        spi_in_byte = b;
        @(negedge clk);
        spi_busy = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic idle_out();
        repeat (TIMEOUT + 8) @(negedge clk);
    endtask

    task automatic run_frame();
        rx_q.delete();
        for (int i = 0; i < tx_q.size(); i++) spi_byte(tx_q[i]);
        idle_out();
        tx_q.delete();
    endtask

    task automatic chk_frame(input string nm);
        chk({nm, "_nrx"}, 32'(rx_q.size()), 32'(exp_rx.size()));
        for (int i = 0; i < exp_rx.size() && i < rx_q.size(); i++)
            chk($sformatf("%s_rx%0d", nm, i), 32'(rx_q[i]), 32'(exp_rx[i]));
        chk({nm, "_ntxn"}, 32'(log_q.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < log_q.size(); i++)
            chk($sformatf("%s_txn%0d", nm, i), 32'(log_q[i]), 32'(exp_log[i]));
        log_q.delete();
        exp_rx.delete();
        exp_log.delete();
    endtask

    vec_t vt[5];

    initial begin
        logic [15:0] a;
        logic [7:0]  d, c;
        int          n, kind;

        vt[0] = '{nb: 4, mosi: b6(8'h9F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00),
                  miso: b6(8'hFF, 8'hA5, 8'h00, 8'hFF, 8'h00, 8'h00), nt: 0,
                  t: t3(txn_t'(0), txn_t'(0), txn_t'(0))};
        vt[1] = '{nb: 5, mosi: b6(8'h01, 8'h12, 8'h34, 8'hAA, 8'hBB, 8'h00),
                  miso: b6(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00), nt: 2,
                  t: t3(tx(1'b1, 16'h1234, 8'hAA), tx(1'b1, 16'h1234 + INC, 8'hBB), txn_t'(0))};
        vt[2] = '{nb: 5, mosi: b6(8'h02, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00),
                  miso: b6(8'hFF, 8'hFF, 8'hFF, 8'h5C, AUTO ? 8'h6D : 8'h5C, 8'h00), nt: 3,
                  t: t3(tx(1'b0, 16'h0010, 8'h5C),
                        tx(1'b0, 16'h0010 + INC, AUTO ? 8'h6D : 8'h5C),
                        tx(1'b0, 16'h0010 + 2 * INC, AUTO ? 8'h7E : 8'h5C))};
        vt[3] = '{nb: 2, mosi: b6(8'h7E, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00),
                  miso: b6(8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00), nt: 0,
                  t: t3(txn_t'(0), txn_t'(0), txn_t'(0))};
        vt[4] = '{nb: 4, mosi: b6(8'h02, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00),
                  miso: b6(8'hFF, 8'hFF, 8'hFF, AUTO ? 8'hAA : 8'hBB, 8'h00, 8'h00), nt: 2,
                  t: t3(tx(1'b0, 16'h1234, AUTO ? 8'hAA : 8'hBB),
                        tx(1'b0, 16'h1234 + INC, 8'hBB), txn_t'(0))};

        ram[16'h0010] = 8'h5C; ram[16'h0011] = 8'h6D; ram[16'h0012] = 8'h7E;
        model_mem[16'h0010] = 8'h5C; model_mem[16'h0011] = 8'h6D; model_mem[16'h0012] = 8'h7E;

        rst = 1'b1; spi_busy = 1'b0; spi_in_byte = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_out",   32'(spi_out_byte),  32'hFF);
        chk("rst_req",   32'(mif.mem_req),   32'h0);
        chk("rst_we",    32'(mif.mem_we),    32'h0);
        chk("rst_addr",  32'(mif.mem_addr),  32'h0);
        chk("rst_wdata", 32'(mif.mem_wdata), 32'h0);
        chk("rst_err",   32'(err_ovr),       32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed frame table
        for (int i = 0; i < 5; i++) begin
            ack_lat = 1 + (i % 3);
            for (int k = 0; k < int'(vt[i].nb); k++) begin
                tx_q.push_back(vt[i].mosi[k]);
                exp_rx.push_back(vt[i].miso[k]);
            end
            for (int k = 0; k < int'(vt[i].nt); k++) begin
                exp_log.push_back(vt[i].t[k]);
                if (vt[i].t[k].we) model_mem[vt[i].t[k].addr] = vt[i].t[k].data;
            end
            run_frame();
            chk_frame($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_err", i), 32'(err_ovr), 32'h0);
        end

        // Write overrun: second data byte arrives while the first is unacked
        ack_lat = 2; hold_ack = 1'b1; rx_q.delete();
        spi_byte(8'h01); spi_byte(8'h00); spi_byte(8'h00); spi_byte(8'h11); spi_byte(8'h22);
        chk("ovr_req_held", 32'(mif.mem_req),   32'h1);
        chk("ovr_wdata",    32'(mif.mem_wdata), 32'h11);
        chk("ovr_err",      32'(err_ovr),       32'h1);
        hold_ack = 1'b0;
        idle_out();
        repeat (5) exp_rx.push_back(8'hFF);
        exp_log.push_back(tx(1'b1, 16'h0000, 8'h11));
        model_mem[16'h0000] = 8'h11;
        chk_frame("ovr");
        chk("ovr_err_sticky", 32'(err_ovr), 32'h1);

        // ID reports the sticky error then clears it
        rx_q.delete();
        spi_byte(8'h9F);
        chk("id_err_cleared", 32'(err_ovr), 32'h0);
        spi_byte(8'h00); spi_byte(8'h00);
        idle_out();
        exp_rx.push_back(8'hFF); exp_rx.push_back(8'hA5); exp_rx.push_back(8'h01);
        chk_frame("id_status");
        chk("id_err_after", 32'(err_ovr), 32'h0);

        // Timeout framing: an aborted write header must not capture later bytes
        tx_q.push_back(8'h01); tx_q.push_back(8'h12);
        run_frame();
        exp_rx.push_back(8'hFF); exp_rx.push_back(8'hFF);
        chk_frame("tmo_abort");
        tx_q.push_back(8'h02); tx_q.push_back(8'h00); tx_q.push_back(8'h00);
        run_frame();
        repeat (3) exp_rx.push_back(8'hFF);
        exp_log.push_back(tx(1'b0, 16'h0000, model_rd(16'h0000)));
        chk_frame("tmo_read");

        // Reset while a read is outstanding
        hold_ack = 1'b1; rx_q.delete();
        spi_byte(8'h02); spi_byte(8'h00); spi_byte(8'h30);
        chk("rr_req",  32'(mif.mem_req),  32'h1);
        chk("rr_we",   32'(mif.mem_we),   32'h0);
        chk("rr_addr", 32'(mif.mem_addr), 32'h0030);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rr_req_drop", 32'(mif.mem_req),  32'h0);
        chk("rr_out",      32'(spi_out_byte), 32'hFF);
        hold_ack = 1'b0;
        repeat (5) @(negedge clk);
        chk("rr_req_stays_low", 32'(mif.mem_req), 32'h0);
        tx_q.push_back(8'h9F); tx_q.push_back(8'h00);
        run_frame();
        exp_rx.push_back(8'hFF); exp_rx.push_back(8'hA5);
        chk_frame("rr_id");

        // Random frames against the transaction-level model
        for (int f = 0; f < 24; f++) begin
            ack_lat = $urandom_range(1, 3);
            kind    = $urandom_range(0, 3);
            n       = $urandom_range(1, 3);
            a       = 16'($urandom);
            case (kind)
                0: begin // write burst
                    tx_q.push_back(8'h01); tx_q.push_back(a[15:8]); tx_q.push_back(a[7:0]);
                    repeat (3) exp_rx.push_back(8'hFF);
                    for (int i = 0; i < n; i++) begin
                        d = 8'($urandom);
                        tx_q.push_back(d);
                        exp_rx.push_back(8'hFF);
                        exp_log.push_back(tx(1'b1, a + 16'(i) * INC, d));
                        model_mem[a + 16'(i) * INC] = d;
                    end
                end
                1: begin // read burst: one request per dummy byte plus the prefetch
                    tx_q.push_back(8'h02); tx_q.push_back(a[15:8]); tx_q.push_back(a[7:0]);
                    repeat (3) exp_rx.push_back(8'hFF);
                    for (int i = 0; i < n; i++) begin
                        tx_q.push_back(8'($urandom));
                        exp_rx.push_back(model_rd(a + 16'(i) * INC));
                    end
                    for (int k = 0; k <= n; k++)
                        exp_log.push_back(tx(1'b0, a + 16'(k) * INC, model_rd(a + 16'(k) * INC)));
                end
                2: begin // ID
                    tx_q.push_back(8'h9F);
                    exp_rx.push_back(8'hFF);
                    for (int i = 0; i < n; i++) begin
                        tx_q.push_back(8'($urandom));
                        exp_rx.push_back(i == 0 ? 8'hA5 : (i == 1 ? 8'h00 : 8'hFF));
                    end
                end
                default: begin // unknown command
                    c = 8'($urandom);
                    while (c == 8'h01 || c == 8'h02 || c == 8'h9F) c = 8'($urandom);
                    tx_q.push_back(c);
                    exp_rx.push_back(8'hFF);
                    for (int i = 0; i < n; i++) begin
                        tx_q.push_back(8'($urandom));
                        exp_rx.push_back(8'hFF);
                    end
                end
            endcase
            run_frame();
            chk_frame($sformatf("rnd%0d", f));
            chk($sformatf("rnd%0d_err", f), 32'(err_ovr), 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
